// File: rtl/ivector_pkg.sv
// Shared constants and helpers for the ivector_queue relay and its FIFO core.
package ivector_pkg;

  localparam int IVECTOR_METH_WIDTH = 6;
  localparam int IVECTOR_V_WIDTH    = 4;
  localparam int IVECTOR_DEPTH      = 4;
  localparam int HEARD_TOTAL_WIDTH  = 16;

  // Width of one stored entry, packed as {v, meth}.
  function automatic int pack_width(input int meth_width, input int v_width);
    return meth_width + v_width;
  endfunction

endpackage

// File: rtl/ivector_queue_fifo_nbase.sv
// fifo_nbase: DEPTH-entry circular FIFO with wrap-bit pointers, full/empty and occupancy.
module fifo_nbase
  import ivector_pkg::*;
#(
  parameter int WIDTH = pack_width(IVECTOR_METH_WIDTH, IVECTOR_V_WIDTH),
  parameter int DEPTH = IVECTOR_DEPTH
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_enq__ENA,
  input  logic [WIDTH-1:0]         in_enq_v,
  output logic                     in_enq__RDY,
  input  logic                     out_deq__ENA,
  output logic                     out_deq__RDY,
  output logic [WIDTH-1:0]         out_first,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, enq, deq;

  // The MSB of each pointer is a wrap bit, so equal low bits mean either empty or full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in_enq__RDY  = !full && nRST;
  assign out_deq__RDY = !empty && nRST;
  assign enq          = in_enq__ENA && in_enq__RDY;
  assign deq          = out_deq__ENA && out_deq__RDY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= in_enq_v;
  end

  assign out_first = mem_q[rd_ptr_q[AW-1:0]];
  assign count     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ivector_queue.sv
// ivector_queue: queued say->heard vector relay with occupancy and delivery count.
// Optional same-cycle pass-through on an empty queue when IVECTOR_QUEUE_BYPASS_EN is defined.
module ivector_queue
  import ivector_pkg::*;
#(
  parameter int METH_WIDTH = IVECTOR_METH_WIDTH,
  parameter int V_WIDTH    = IVECTOR_V_WIDTH,
  parameter int DEPTH      = IVECTOR_DEPTH
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         request_say__ENA,
  input  logic [METH_WIDTH-1:0]        request_say_meth,
  input  logic [V_WIDTH-1:0]           request_say_v,
  output logic                         request_say__RDY,
  output logic                         ind_heard__ENA,
  output logic [METH_WIDTH-1:0]        ind_heard_meth,
  output logic [V_WIDTH-1:0]           ind_heard_v,
  input  logic                         ind_heard__RDY,
  output logic [$clog2(DEPTH):0]       count,
  output logic [HEARD_TOTAL_WIDTH-1:0] heardTotal
);

  localparam int PW = pack_width(METH_WIDTH, V_WIDTH);

  logic [PW-1:0]                fifo_first, say_packed, heard_packed;
  logic                         fifo_valid, fifo_deq, bypass;
  logic [HEARD_TOTAL_WIDTH-1:0] heard_total_q, heard_total_d;

  assign say_packed = {request_say_v, request_say_meth};

`ifdef IVECTOR_QUEUE_BYPASS_EN
  // fifo_valid already folds in nRST, so !fifo_valid stands for "empty" once gated by nRST.
  assign bypass = nRST && !fifo_valid && request_say__ENA && ind_heard__RDY;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_deq = fifo_valid && ind_heard__RDY;

  fifo_nbase #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (request_say__ENA && !bypass),
    .in_enq_v     (say_packed),
    .in_enq__RDY  (request_say__RDY),
    .out_deq__ENA (fifo_deq),
    .out_deq__RDY (fifo_valid),
    .out_first    (fifo_first),
    .count        (count)
  );

  // Heard data is forced to zero when nothing is deliverable, hiding stale storage.
  always_comb begin
    heard_packed = '0;
    if (fifo_valid)  heard_packed = fifo_first;
    else if (bypass) heard_packed = say_packed;
  end

  assign ind_heard__ENA = fifo_deq || bypass;
  assign ind_heard_meth = heard_packed[METH_WIDTH-1:0];
  assign ind_heard_v    = heard_packed[PW-1:METH_WIDTH];

  assign heard_total_d = heard_total_q + {{(HEARD_TOTAL_WIDTH-1){1'b0}}, ind_heard__ENA};

  always_ff @(posedge CLK) begin
    if (!nRST) heard_total_q <= '0;
    else       heard_total_q <= heard_total_d;
  end

  assign heardTotal = heard_total_q;

endmodule
